prd_ctrl: RTL and testbench

- Branch-prediction recovery controller between the ID-stage static predictor (BTFN, JAL/JALR always taken) and EX-stage branch resolution.
- Tracks in-flight predictions in a small FIFO and compares each against the EX outcome.
- On mispredict, sequences pipeline flush and PC redirect.
- Holds ID on JALR load-use hazards and on tracking-FIFO full; keeps prediction statistics counters.

---
 rtl/prd_ctrl_pkg.sv | 32 +++
 rtl/prd_fifo.sv | 54 +++++
 rtl/prd_ctrl.sv | 125 ++++++++++++
 tb/tb_prd_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prd_ctrl_pkg.sv
// rtl/prd_ctrl_pkg.sv - shared types and constants for the prediction recovery controller
package prd_ctrl_pkg;

    typedef logic [31:0] InstAddrBus;
    typedef logic [4:0]  RegAddrBus;

    localparam logic       JumpEnable  = 1'b1;
    localparam logic       JumpDisable = 1'b0;
    localparam InstAddrBus ZeroWord    = 32'h0000_0000;

    typedef enum logic {
        PRD_ST_RUN   = 1'b0,
        PRD_ST_FLUSH = 1'b1
    } prd_state_e;

    // One in-flight prediction: 32 + 1 + 32 = 65 bits
    typedef struct packed {
        InstAddrBus pc;
        logic       prd_taken;
        InstAddrBus prd_target;
    } prd_entry_t;

    localparam int PRD_ENTRY_W = $bits(prd_entry_t);

    // A target mismatch only matters when both sides agree the branch was taken
    function automatic logic is_mispredict(input prd_entry_t e, input logic taken,
                                           input InstAddrBus target);
        return (e.prd_taken != taken) ||
               ((e.prd_taken == JumpEnable) && (taken == JumpEnable) && (e.prd_target != target));
    endfunction

endpackage

// File: rtl/prd_fifo.sv
// rtl/prd_fifo.sv - small synchronous FIFO holding in-flight predictions
module prd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    // A pop in the same cycle frees the slot, so push+pop while full is accepted
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    // Entry storage; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (!rst && !clear && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; clear behaves like a reset
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (!do_push && do_pop) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/prd_ctrl.sv
// rtl/prd_ctrl.sv - branch prediction tracking, mispredict flush/redirect and statistics
module prd_ctrl
    import prd_ctrl_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_push_i,
    input  logic [31:0]      id_instaddr_i,
    input  logic             id_prd_jump_en_i,
    input  logic [31:0]      id_prd_target_i,
    input  logic             id_jalr_i,
    input  logic             id_rs1_read_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic             ex_is_load_i,
    input  logic             ex_wen_i,
    input  logic [4:0]       ex_wr_addr_i,
    input  logic             ex_resolve_i,
    input  logic             ex_taken_i,
    input  logic [31:0]      ex_target_i,
    output logic             hold_id_o,
    output logic             flush_o,
    output logic             redirect_en_o,
    output logic [31:0]      redirect_addr_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mis_cnt_o,
    output logic             err_o
);
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    prd_state_e state;
    logic [FW-1:0] flush_cnt;
    prd_entry_t head;
    prd_entry_t new_entry;
    logic fifo_full;
    logic fifo_empty;
    logic in_run;
    logic valid_resolve;
    logic mispredict;
    logic fifo_push;
    logic ldhaz;
    InstAddrBus corr_addr;

    assign in_run        = (state == PRD_ST_RUN);
    assign valid_resolve = in_run & ex_resolve_i & ~fifo_empty;
    assign mispredict    = valid_resolve & is_mispredict(head, ex_taken_i, ex_target_i);
    // Anything pushed alongside a mispredict is younger and gets flushed anyway
    assign fifo_push     = in_run & id_push_i & ~mispredict;
    assign corr_addr     = ex_taken_i ? ex_target_i : (head.pc + 32'd4);

    assign new_entry.pc         = id_instaddr_i;
    assign new_entry.prd_taken  = id_prd_jump_en_i;
    assign new_entry.prd_target = id_prd_target_i;

    // The predictor forwards rs1 from EX, which is useless while EX holds a load
    assign ldhaz = id_jalr_i & id_rs1_read_i & ex_is_load_i & ex_wen_i &
                   (ex_wr_addr_i == id_rs1_addr_i) & (id_rs1_addr_i != RegAddrBus'(0));

    assign hold_id_o = (fifo_full & ~ex_resolve_i) | ldhaz | (state == PRD_ST_FLUSH);

    prd_fifo #(
        .DEPTH (DEPTH),
        .W     (PRD_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (valid_resolve),
        .clear (mispredict),
        .wdata (new_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Recovery sequencer: one redirect pulse, then FLUSH_CYC cycles of flush
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= PRD_ST_RUN;
            flush_cnt       <= '0;
            flush_o         <= 1'b0;
            redirect_en_o   <= 1'b0;
            redirect_addr_o <= ZeroWord;
        end else begin
            redirect_en_o <= 1'b0;
            case (state)
                PRD_ST_RUN: begin
                    if (mispredict) begin
                        state           <= PRD_ST_FLUSH;
                        flush_cnt       <= FW'(FLUSH_CYC - 1);
                        flush_o         <= 1'b1;
                        redirect_en_o   <= 1'b1;
                        redirect_addr_o <= corr_addr;
                    end
                end
                PRD_ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= PRD_ST_RUN;
                        flush_o <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FW'(1);
                    end
                end
                default: state <= PRD_ST_RUN;
            endcase
        end
    end

    // Statistics and sticky error for resolves that have nothing to match
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_o  <= '0;
            mis_cnt_o <= '0;
            err_o     <= 1'b0;
        end else begin
            if (valid_resolve)                        br_cnt_o  <= br_cnt_o + CNT_W'(1);
            if (mispredict)                           mis_cnt_o <= mis_cnt_o + CNT_W'(1);
            if (in_run && ex_resolve_i && fifo_empty) err_o     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prd_ctrl.sv
// tb/tb_prd_ctrl.sv - randomized and directed self-checking bench for prd_ctrl
module tb_prd_ctrl;
    localparam int DEPTH     = 4;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 32;

    logic clk = 1'b0;
    logic rst;
    logic id_push_i;
    logic [31:0] id_instaddr_i;
    logic id_prd_jump_en_i;
    logic [31:0] id_prd_target_i;
    logic id_jalr_i;
    logic id_rs1_read_i;
    logic [4:0] id_rs1_addr_i;
    logic ex_is_load_i;
    logic ex_wen_i;
    logic [4:0] ex_wr_addr_i;
    logic ex_resolve_i;
    logic ex_taken_i;
    logic [31:0] ex_target_i;
    logic hold_id_o;
    logic flush_o;
    logic redirect_en_o;
    logic [31:0] redirect_addr_o;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] mis_cnt_o;
    logic err_o;

    prd_ctrl #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_push_i(id_push_i), .id_instaddr_i(id_instaddr_i),
        .id_prd_jump_en_i(id_prd_jump_en_i), .id_prd_target_i(id_prd_target_i),
        .id_jalr_i(id_jalr_i), .id_rs1_read_i(id_rs1_read_i), .id_rs1_addr_i(id_rs1_addr_i),
        .ex_is_load_i(ex_is_load_i), .ex_wen_i(ex_wen_i), .ex_wr_addr_i(ex_wr_addr_i),
        .ex_resolve_i(ex_resolve_i), .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
        .hold_id_o(hold_id_o), .flush_o(flush_o), .redirect_en_o(redirect_en_o),
        .redirect_addr_o(redirect_addr_o), .br_cnt_o(br_cnt_o), .mis_cnt_o(mis_cnt_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];
    int fl;
    logic m_ren;
    logic [31:0] m_raddr;
    logic [31:0] m_br;
    logic [31:0] m_mis;
    logic m_err;
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; id_push_i = 0; id_instaddr_i = 0; id_prd_jump_en_i = 0; id_prd_target_i = 0;
        id_jalr_i = 0; id_rs1_read_i = 0; id_rs1_addr_i = 0; ex_is_load_i = 0; ex_wen_i = 0;
        ex_wr_addr_i = 0; ex_resolve_i = 0; ex_taken_i = 0; ex_target_i = 0;
    endtask

    function automatic logic exp_hold();
        logic ld;
        ld = id_jalr_i && id_rs1_read_i && ex_is_load_i && ex_wen_i &&
             (ex_wr_addr_i == id_rs1_addr_i) && (id_rs1_addr_i != 0);
        return ((q.size() == DEPTH) && !ex_resolve_i) || ld || (fl > 0);
    endfunction

    // Reference behaviour at a clock edge, from the prediction-tracking rules
    task automatic model_edge();
        bit mis;
        bit popped;
        int sz;
        ent_t h;
        ent_t n;
        if (rst) begin
            q.delete(); fl = 0; m_ren = 0; m_raddr = 0; m_br = 0; m_mis = 0; m_err = 0;
            return;
        end
        m_ren = 0;
        if (fl > 0) begin
            fl--;
            return;
        end
        sz = q.size(); popped = 0; mis = 0;
        if (ex_resolve_i) begin
            if (sz == 0) m_err = 1;
            else begin
                h = q.pop_front(); popped = 1; m_br++;
                mis = (h.taken != ex_taken_i) || (h.taken && ex_taken_i && h.tgt != ex_target_i);
                if (mis) begin
                    m_mis++; q.delete(); m_ren = 1; fl = FLUSH_CYC;
                    m_raddr = ex_taken_i ? ex_target_i : h.pc + 32'd4;
                end
            end
        end
        if (!mis && id_push_i && (sz < DEPTH || popped)) begin
            n.pc = id_instaddr_i; n.taken = id_prd_jump_en_i; n.tgt = id_prd_target_i;
            q.push_back(n);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("hold_id", 32'(hold_id_o), 32'(exp_hold()));
        @(posedge clk);
        model_edge();
        #1;
        chk("flush", 32'(flush_o), 32'(fl > 0));
        chk("redirect_en", 32'(redirect_en_o), 32'(m_ren));
        chk("redirect_addr", redirect_addr_o, m_raddr);
        chk("br_cnt", br_cnt_o, m_br);
        chk("mis_cnt", mis_cnt_o, m_mis);
        chk("err", 32'(err_o), 32'(m_err));
    endtask

    task automatic push_br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        id_push_i = 1; id_instaddr_i = pc; id_prd_jump_en_i = tk; id_prd_target_i = tgt;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt);
        ex_resolve_i = 1; ex_taken_i = tk; ex_target_i = tgt;
    endtask

    initial begin
        idle();
        q.delete(); fl = 0; m_ren = 0; m_raddr = 0; m_br = 0; m_mis = 0; m_err = 0;
        rst = 1;
        step();
        chk("reset_flush", 32'(flush_o), 32'd0);
        chk("reset_br", br_cnt_o, 32'd0);
        idle();

        // Correctly predicted backward BEQ
        push_br(32'h100, 1, 32'hF0); step(); idle();
        resolve(1, 32'hF0); step(); idle();
        chk("beq_br", br_cnt_o, 32'd1);
        chk("beq_mis", mis_cnt_o, 32'd0);
        chk("beq_redir", 32'(redirect_en_o), 32'd0);

        // Forward BNE predicted not-taken, actually taken
        push_br(32'h200, 0, 32'h240); step(); idle();
        resolve(1, 32'h240); step(); idle();
        chk("bne_redir_en", 32'(redirect_en_o), 32'd1);
        chk("bne_redir_addr", redirect_addr_o, 32'h240);
        chk("bne_flush1", 32'(flush_o), 32'd1);
        chk("bne_mis", mis_cnt_o, 32'd1);
        step();
        chk("bne_flush2", 32'(flush_o), 32'd1);
        chk("bne_redir_pulse", 32'(redirect_en_o), 32'd0);
        step();
        chk("bne_flush_end", 32'(flush_o), 32'd0);

        // Backward branch predicted taken, actually not taken
        push_br(32'h300, 1, 32'h2C0); step(); idle();
        resolve(0, 32'h0); step(); idle();
        chk("nt_redir_addr", redirect_addr_o, 32'h304);
        step(); step();

        // JALR load-use hazard, then the x0 case
        id_jalr_i = 1; id_rs1_read_i = 1; id_rs1_addr_i = 5'd1;
        ex_is_load_i = 1; ex_wen_i = 1; ex_wr_addr_i = 5'd1;
        #1; chk("ldhaz_x1", 32'(hold_id_o), 32'd1);
        step();
        id_rs1_addr_i = 5'd0; ex_wr_addr_i = 5'd0;
        #1; chk("ldhaz_x0", 32'(hold_id_o), 32'd0);
        step(); idle();
        #1; chk("ldhaz_gone", 32'(hold_id_o), 32'd0);

        // Fill the FIFO, then push+resolve while full
        for (int i = 0; i < DEPTH; i++) begin
            push_br(32'h1000 + 32'(i) * 4, 1, 32'h2000 + 32'(i)); step();
        end
        idle();
        #1; chk("full_hold", 32'(hold_id_o), 32'd1);
        push_br(32'h1100, 1, 32'h2100); resolve(q[0].taken, q[0].tgt);
        #1; chk("full_pushpop_hold", 32'(hold_id_o), 32'd0);
        step(); idle();
        for (int i = 0; i < DEPTH; i++) begin
            resolve(q[0].taken, q[0].tgt); step();
        end
        idle();
        chk("drain_err", 32'(err_o), 32'd0);
        chk("drain_mis", mis_cnt_o, 32'd2);
        chk("drain_br", br_cnt_o, 32'd8);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            idle();
            if ($urandom_range(1, 0) == 1) begin
                push_br({$urandom_range(255, 0), 2'b00}, 1'($urandom), $urandom);
            end
            id_jalr_i = 1'($urandom); id_rs1_read_i = 1'($urandom);
            id_rs1_addr_i = 5'($urandom_range(3, 0));
            ex_is_load_i = 1'($urandom); ex_wen_i = 1'($urandom);
            ex_wr_addr_i = 5'($urandom_range(3, 0));
            if ($urandom_range(9, 0) < 4) begin
                if (q.size() > 0) begin
                    ex_resolve_i = 1;
                    ex_taken_i  = ($urandom_range(3, 0) != 0) ? q[0].taken : ~q[0].taken;
                    ex_target_i = ($urandom_range(3, 0) != 0) ? q[0].tgt : $urandom;
                end else if ($urandom_range(7, 0) == 0) begin
                    resolve(1'($urandom), $urandom);
                end
            end
            step();
        end
        idle();
        step(); step(); step();

        // Reset in the first flush cycle
        push_br(32'h400, 0, 32'h0); step(); idle();
        resolve(1, 32'h500); step(); idle();
        chk("pre_rst_flush", 32'(flush_o), 32'd1);
        rst = 1; step(); idle();
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_redir", 32'(redirect_en_o), 32'd0);
        chk("rst_br", br_cnt_o, 32'd0);
        chk("rst_mis", mis_cnt_o, 32'd0);
        step();
        chk("rst_no_flush", 32'(flush_o), 32'd0);
        resolve(1, 32'h0); step(); idle();
        chk("empty_resolve_err", 32'(err_o), 32'd1);
        chk("empty_resolve_br", br_cnt_o, 32'd0);
        step();
        chk("err_sticky", 32'(err_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
